stream_demux_n: RTL and testbench
=================================

Name: stream_demux_n

Overview:
- Registered, parametrised 1-to-CH demultiplexer for streaming data with a valid/ready handshake on every port.
- Routes each input beat to the channel named by a select field, or to all channels in broadcast mode.
- Holds each beat in a single output stage until every targeted channel has accepted it.
- Sits between a single producer and CH independent consumers. Replaces the earlier fixed 1-to-4, 1-bit combinational demux.

Parameters:
- WIDTH, 8, data bits per beat.
- CH, 4, number of output channels; 2..16, need not be a power of two.
- SELW, $clog2(CH), select field width (derived; do not override).
- CNTW, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  input beat data.
- in_sel  in  SELW  target channel index.
- in_bcast  in  1  1 = deliver the beat to all CH channels; in_sel is ignored.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- out_data  out  WIDTH  held beat; one shared bus presented to all channels.
- out_valid  out  CH  per-channel valid; bit i is set when channel i has not yet taken the held beat.
- out_ready  in  CH  per-channel consumer ready.
- busy  out  1  held beat still pending on at least one channel (= |out_valid).
- sel_err  out  1  sticky: a non-broadcast beat arrived with in_sel >= CH.
- beat_cnt  out  CNTW  count of accepted input beats.

Behaviour:
- State registers: data_q (WIDTH), mask_q (CH), sel_err, beat_cnt.
- Output mapping: out_data = data_q; out_valid = mask_q.
- States:
  - EMPTY: mask_q == 0.
  - HOLD: mask_q != 0; partially drained when some bits have already cleared.
- in_ready = ((mask_q & ~out_ready) == 0). It is combinational from out_ready and mask_q, with no path from in_valid.
- Accept: when in_valid & in_ready, on the next edge:
  - data_q <= in_data;
  - mask_q <= in_bcast ? all ones : onehot(in_sel);
  - beat_cnt <= beat_cnt + 1, wrapping modulo 2^CNTW.
- Otherwise: mask_q <= mask_q & ~out_ready. Bits clear individually as each channel handshakes (out_valid[i] & out_ready[i]).
- Simultaneous last drain and new accept: the new mask replaces the old one. No bubble, so full throughput is 1 beat/cycle.
- Latency: a beat accepted at edge n is visible on out_valid/out_data after edge n; minimum 1 cycle.
- Stability: data_q is unchanged while mask_q != 0, except on an accept cycle.
- A channel that has already taken the beat sees out_valid[i]=0 even while other channels are still pending. It never receives a duplicate.
- out_ready[i] while out_valid[i]=0 is ignored.
- Invalid select (in_bcast=0, in_sel >= CH; only possible when CH is not a power of two):
  - the beat is accepted and dropped (mask 0);
  - beat_cnt still increments;
  - sel_err is set and stays set until rst.
- Broadcast completes only when all CH channels have handshaked. Any order, any cycles.
- Reset (any time, including mid-HOLD): data_q=0, mask_q=0, sel_err=0, beat_cnt=0. Resulting outputs: out_valid=0, out_data=0, busy=0, in_ready=1. Any held beat is discarded.
- No combinational path from in_data/in_sel to any output.

Decomposition:
- Shared package stream_demux_pkg holds:
  - the default WIDTH/CH/CNTW constants;
  - a function onehot_mask(sel, bcast) returning CH bits, with all zeros for sel >= CH.
- One sub-module, demux_dec: a combinational generalised decoder from SELW+bcast to a CH-bit mask. It is the parametrised successor of the old 1-to-4 decode.
- Handshake and registers remain in stream_demux_n.

Test Plan:
- Single routed beat: reset, CH=4; drive in_data=8'hA5, in_sel=2, in_valid=1, out_ready=4'b1111 -> one cycle later out_valid=4'b0100, out_data=8'hA5; cleared next cycle; beat_cnt=1.
- Back-pressure: in_sel=1, out_ready[1]=0 for 3 cycles -> out_valid=4'b0010 and data stable for 3 cycles; in_ready=0 throughout; in_ready=1 in the cycle out_ready[1] rises.
- Broadcast staggered drain: in_bcast=1, data 8'h3C; raise out_ready bits in order 0,2,1,3 on successive cycles -> out_valid goes 1111, 1110, 1010, 1000, 0000; in_ready=1 only in the last drain cycle; no duplicate delivery.
- Streaming: 8 beats with sel 0,1,2,3,0,1,2,3, all ready -> one beat per cycle, no bubbles; beat_cnt=8; each channel sees exactly 2 beats in order.
- Invalid select: CH=5, in_sel=6, in_bcast=0 -> out_valid stays 0; sel_err=1 sticky; beat_cnt increments.
- Reset mid-HOLD: assert rst asynchronously while out_valid=4'b0100 -> out_valid=0, busy=0, beat_cnt=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants, state naming and the select decode
// function for the stream_demux_n block.
//   WIDTH_DEF / CH_DEF / CNTW_DEF : default beat width, channel count, counter width
//   CH_MAX                        : largest supported channel count
//   state_e                       : EMPTY (nothing held) / HOLD (beat pending)
//   onehot_mask()                 : select+broadcast -> channel mask (CH_MAX bits)
package stream_demux_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CH_DEF    = 4;
    localparam int CNTW_DEF  = 16;
    localparam int CH_MAX    = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Broadcast sets every implemented channel; otherwise only bit 'sel'.
    // A select at or beyond 'ch' matches no bit and yields an all-zero mask.
    function automatic logic [CH_MAX-1:0] onehot_mask(input int unsigned sel,
                                                      input logic        bcast,
                                                      input int unsigned ch);
        logic [CH_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CH_MAX; i++) begin
            if (i < ch) m[i] = bcast || (i == sel);
        end
        return m;
    endfunction

endpackage

// File: rtl/demux_dec.sv
// demux_dec: combinational decoder from a channel select plus broadcast flag
// to a CH-bit target mask.
//   i_sel   in  SELW  target channel index
//   i_bcast in  1     target every channel, i_sel ignored
//   o_mask  out CH    target mask; zero for an out-of-range select
module demux_dec
    import stream_demux_pkg::*;
#(
    parameter int CH   = CH_DEF,
    parameter int SELW = $clog2(CH)
) (
    input  logic [SELW-1:0] i_sel,
    input  logic            i_bcast,
    output logic [CH-1:0]   o_mask
);

    always_comb begin
        o_mask = CH'(onehot_mask(32'(i_sel), i_bcast, CH));
    end

endmodule

// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-CH stream demultiplexer. Each accepted
// beat is held in one output stage until every targeted channel has taken it.
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_sel      beat data and target channel
//   in_bcast            deliver to all channels
//   in_valid/in_ready   producer handshake
//   out_data            held beat, shared by all channels
//   out_valid/out_ready per-channel handshake
//   busy                a held beat is still pending somewhere
//   sel_err             sticky flag for an out-of-range non-broadcast select
//   beat_cnt            accepted-beat count, wraps
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CH    = CH_DEF,
    parameter int SELW  = $clog2(CH),
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  in_sel,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CH-1:0]    out_valid,
    input  logic [CH-1:0]    out_ready,
    output logic             busy,
    output logic             sel_err,
    output logic [CNTW-1:0]  beat_cnt
);

    logic [WIDTH-1:0] r_data;
    logic [CH-1:0]    r_mask;
    logic             r_sel_err;
    logic [CNTW-1:0]  r_beat_cnt;

    logic [CH-1:0]    w_dec_mask;
    logic             w_accept;
    logic             w_sel_bad;
    state_e           w_state;

    demux_dec #(
        .CH   (CH),
        .SELW (SELW)
    ) u_dec (
        .i_sel   (in_sel),
        .i_bcast (in_bcast),
        .o_mask  (w_dec_mask)
    );

    // Ready as soon as every still-pending channel is handshaking this cycle,
    // so the last drain and the next accept share one edge (no bubble).
    assign in_ready  = ((r_mask & ~out_ready) == '0);
    assign w_accept  = in_valid & in_ready;
    // Broadcast and in-range selects always decode non-zero, so an empty
    // mask can only come from an out-of-range select.
    assign w_sel_bad = (w_dec_mask == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_mask     <= '0;
            r_sel_err  <= 1'b0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_data     <= in_data;
            r_mask     <= w_dec_mask;
            r_beat_cnt <= r_beat_cnt + CNTW'(1);
            r_sel_err  <= r_sel_err | w_sel_bad;
        end else begin
            // Each channel's bit drops on its own handshake; ready on an
            // already-cleared bit has no effect.
            r_mask <= r_mask & ~out_ready;
        end
    end

    // The mask itself is the state register; name it for readability.
    always_comb begin
        w_state = (r_mask == '0) ? ST_EMPTY : ST_HOLD;
    end

    assign out_data  = r_data;
    assign out_valid = r_mask;
    assign busy      = (w_state == ST_HOLD);
    assign sel_err   = r_sel_err;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

    logic        clk = 1'b0;
    logic        rst;

    // CH=4 instance
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast, in_valid, in_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_valid, out_ready;
    logic        busy, sel_err;
    logic [15:0] beat_cnt;

    // CH=5 instance (out-of-range selects exist)
    logic [7:0]  d5_in_data;
    logic [2:0]  d5_in_sel;
    logic        d5_in_bcast, d5_in_valid, d5_in_ready;
    logic [7:0]  d5_out_data;
    logic [4:0]  d5_out_valid, d5_out_ready;
    logic        d5_busy, d5_sel_err;
    logic [15:0] d5_beat_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: per-channel queue of beats still owed to that channel.
    logic [7:0] q [4][$];
    int         exp_cnt = 0;
    int         deliv [4];

    always #5 clk = ~clk;

    stream_demux_n #(.WIDTH(8), .CH(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .sel_err(sel_err), .beat_cnt(beat_cnt)
    );

    stream_demux_n #(.WIDTH(8), .CH(5), .CNTW(16)) dut5 (
        .clk(clk), .rst(rst),
        .in_data(d5_in_data), .in_sel(d5_in_sel), .in_bcast(d5_in_bcast),
        .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .out_data(d5_out_data), .out_valid(d5_out_valid), .out_ready(d5_out_ready),
        .busy(d5_busy), .sel_err(d5_sel_err), .beat_cnt(d5_beat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model mid-cycle, then advance
    // the model by what the coming edge must do.
    task automatic tick();
        logic [3:0] ev;
        logic       er;
        @(negedge clk);
        ev = '0;
        er = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (q[i].size() != 0);
            if (ev[i] && !out_ready[i]) er = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(ev));
        check("busy",      32'(busy),      32'(|ev));
        check("in_ready",  32'(in_ready),  32'(er));
        check("beat_cnt",  32'(beat_cnt),  32'(exp_cnt % 65536));
        check("sel_err",   32'(sel_err),   32'd0);
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) check("out_data", 32'(out_data), 32'(q[i][0]));
            if (out_valid[i] && out_ready[i]) deliv[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            if (ev[i] && out_ready[i]) void'(q[i].pop_front());
        end
        if (in_valid && er) begin
            exp_cnt++;
            for (int i = 0; i < 4; i++) begin
                if (in_bcast || int'(in_sel) == i) q[i].push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ord [4];
        int         c0;
        ord = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

        rst = 1'b1;
        in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = '0;
        d5_in_data = '0; d5_in_sel = '0; d5_in_bcast = 1'b0; d5_in_valid = 1'b0; d5_out_ready = '0;
        for (int i = 0; i < 4; i++) deliv[i] = 0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_beat_cnt",  32'(beat_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single routed beat
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2; out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        check("single_vld", 32'(out_valid), 32'b0100);
        check("single_dat", 32'(out_data),  32'hA5);
        tick();
        tick();
        check("single_cnt", 32'(beat_cnt), 32'd1);

        // Back-pressure on channel 1, with a competing beat waiting
        in_valid = 1'b1; in_data = 8'h5A; in_sel = 2'd1; out_ready = 4'b1111;
        tick();
        out_ready = 4'b1101; in_data = 8'h77; in_sel = 2'd3;
        tick(); tick(); tick();
        out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick(); tick();

        // Broadcast, staggered drain 0,2,1,3
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h3C; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0; in_bcast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            out_ready = ord[k];
            tick();
        end
        out_ready = 4'b0000;
        tick();

        // Streaming, full throughput
        for (int i = 0; i < 4; i++) deliv[i] = 0;
        c0 = exp_cnt;
        out_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_sel = 2'(k % 4); in_data = 8'(8'h10 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("stream_cnt", 32'(beat_cnt), 32'(c0 + 8));
        for (int i = 0; i < 4; i++) check("stream_deliv", 32'(deliv[i]), 32'd2);

        // Invalid select on the CH=5 instance
        d5_in_valid = 1'b1; d5_in_sel = 3'd6; d5_in_data = 8'h99; d5_out_ready = 5'b00000;
        @(posedge clk); #1;
        d5_in_valid = 1'b0;
        check("inv_vld",  32'(d5_out_valid), 32'd0);
        check("inv_busy", 32'(d5_busy),      32'd0);
        check("inv_err",  32'(d5_sel_err),   32'd1);
        check("inv_cnt",  32'(d5_beat_cnt),  32'd1);
        d5_in_valid = 1'b1; d5_in_sel = 3'd4; d5_in_data = 8'h44;
        @(posedge clk); #1;
        d5_in_valid = 1'b0;
        check("ch4_vld", 32'(d5_out_valid), 32'b10000);
        check("ch4_dat", 32'(d5_out_data),  32'h44);
        check("ch4_cnt", 32'(d5_beat_cnt),  32'd2);
        d5_out_ready = 5'b11111;
        @(posedge clk); #1;
        check("ch4_drain",  32'(d5_out_valid), 32'd0);
        check("err_sticky", 32'(d5_sel_err),   32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_sel    = 2'($urandom);
            in_bcast  = ($urandom_range(0, 7) == 0);
            out_ready = 4'($urandom);
            tick();
        end
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b1111;
        tick(); tick();

        // Asynchronous reset while holding a beat
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC3; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0;
        tick();
        check("hold_vld", 32'(out_valid), 32'b0100);
        #2 rst = 1'b1;
        #1;
        check("arst_vld",   32'(out_valid),  32'd0);
        check("arst_busy",  32'(busy),       32'd0);
        check("arst_cnt",   32'(beat_cnt),   32'd0);
        check("arst_dat",   32'(out_data),   32'd0);
        check("arst_rdy",   32'(in_ready),   32'd1);
        check("arst_err5",  32'(d5_sel_err), 32'd0);
        for (int i = 0; i < 4; i++) q[i].delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h0F; out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
